// File: rtl/sr_jk_register_bank.sv
// rtl/sr_jk_register_bank.sv - multi-bit SR/JK/D/T storage register with sticky illegal-input flags
module sr_jk_register_bank #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter int               SR_CONFLICT = 0,
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             clr_err,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n,
  output logic [WIDTH-1:0] illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Reject parameter combinations the logic was not built for.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sr_jk_register_bank: WIDTH must be in 1..32");
  end
  if (SR_CONFLICT < 0 || SR_CONFLICT > 3) begin : g_bad_conflict
    $error("sr_jk_register_bank: SR_CONFLICT must be in 0..3");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("sr_jk_register_bank: CNT_W must be at least 1");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ill_vec;
  logic [WIDTH-1:0] sr_conflict_val;

  // Next state for storage bits, sticky flags and the saturating event counter.
  always_comb begin
    q_d             = q_q;
    illegal_d       = illegal_q;
    cnt_d           = cnt_q;
    ill_vec         = '0;
    sr_conflict_val = '0;

    if (en) begin
      case (mode)
        MODE_SR: begin
          ill_vec = S & R;
          // Bits with S=R=1 take the configured conflict action; value 3 falls back to hold.
          if (SR_CONFLICT == 1)      sr_conflict_val = ill_vec;
          else if (SR_CONFLICT == 2) sr_conflict_val = '0;
          else                       sr_conflict_val = q_q & ill_vec;
          q_d = (q_q & ~(S | R)) | (S & ~R) | sr_conflict_val;
        end
        MODE_JK: q_d = (S & ~q_q) | (~R & q_q);
        MODE_D:  q_d = S;
        MODE_T:  q_d = q_q ^ S;
      endcase

      // A clear still lets an event from the same cycle register.
      if (clr_err) begin
        illegal_d = ill_vec;
        cnt_d     = (|ill_vec) ? CNT_ONE : '0;
      end else begin
        illegal_d = illegal_q | ill_vec;
        if ((|ill_vec) && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // State registers; reset is asynchronous and overrides every input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q       <= RESET_VAL;
      illegal_q <= '0;
      cnt_q     <= '0;
    end else begin
      q_q       <= q_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign Q           = q_q;
  assign Q_n         = ~q_q;
  assign illegal     = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_sr_jk_register_bank.sv
// tb/tb_sr_jk_register_bank.sv - randomized and directed bench for sr_jk_register_bank
module tb_sr_jk_register_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] S, R;
  logic       clr_err;

  logic [3:0] q1, qn1, ill1;
  logic [1:0] cnt1;
  logic [3:0] q2, qn2, ill2;
  logic [7:0] cnt2;

  logic [13:0] obs1;
  logic [19:0] obs2;
  assign obs1 = {q1, qn1, ill1, cnt1};
  assign obs2 = {q2, qn2, ill2, cnt2};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, index 0 = hold-on-conflict unit, 1 = set-on-conflict unit.
  logic [3:0] mq   [2];
  logic [3:0] mill [2];
  int         mcnt [2];
  int         cmax [2] = '{3, 255};
  int         conf [2] = '{0, 1};
  logic [3:0] rst_val [2] = '{4'b1010, 4'b0000};

  always #5 clk = ~clk;

  sr_jk_register_bank #(.WIDTH(4), .RESET_VAL(4'b1010), .SR_CONFLICT(0), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .S(S), .R(R), .clr_err(clr_err),
    .Q(q1), .Q_n(qn1), .illegal(ill1), .illegal_cnt(cnt1)
  );

  sr_jk_register_bank #(.WIDTH(4), .RESET_VAL(4'b0000), .SR_CONFLICT(1), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .S(S), .R(R), .clr_err(clr_err),
    .Q(q2), .Q_n(qn2), .illegal(ill2), .illegal_cnt(cnt2)
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k] = rst_val[k]; mill[k] = '0; mcnt[k] = 0;
    end
  endtask

  // Apply one set of inputs over one rising edge and advance the model from the rules.
  task automatic step(input logic e, input logic [1:0] m, input logic [3:0] s,
                      input logic [3:0] r, input logic c);
    logic [3:0] conflict_bits;
    en = e; mode = m; S = s; R = r; clr_err = c;
    @(posedge clk);
    #1;
    if (e) begin
      conflict_bits = (m == 2'd0) ? (s & r) : 4'b0000;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) begin
          if (m == 2'd0) begin
            if (s[i] && !r[i])      mq[k][i] = 1'b1;
            else if (!s[i] && r[i]) mq[k][i] = 1'b0;
            else if (s[i] && r[i]) begin
              if (conf[k] == 1)      mq[k][i] = 1'b1;
              else if (conf[k] == 2) mq[k][i] = 1'b0;
            end
          end else if (m == 2'd1) begin
            if (s[i] && r[i])  mq[k][i] = !mq[k][i];
            else if (s[i])     mq[k][i] = 1'b1;
            else if (r[i])     mq[k][i] = 1'b0;
          end else if (m == 2'd2) begin
            mq[k][i] = s[i];
          end else if (s[i]) begin
            mq[k][i] = !mq[k][i];
          end
        end
        if (c) begin
          mill[k] = conflict_bits;
          mcnt[k] = (conflict_bits != 0) ? 1 : 0;
        end else begin
          mill[k] = mill[k] | conflict_bits;
          if (conflict_bits != 0 && mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [13:0] e1;
    logic [19:0] e2;
    e1 = {4'b1010, 4'b0101, 4'b0000, 2'd0};
    e2 = {4'b0000, 4'b1111, 4'b0000, 8'd0};
    n_checks++; if (obs1 !== e1) $display("FAIL reset_dut1 act=%b exp=%b", obs1, e1); else n_pass++;
    n_checks++; if (obs2 !== e2) $display("FAIL reset_dut2 act=%b exp=%b", obs2, e2); else n_pass++;
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 2'd2, 4'b0101, 4'b0000, 1'b0);
    step(1'b1, 2'd0, 4'b0001, 4'b0001, 1'b0);
    e1 = {4'b0101, 4'b1010, 4'b0001, 2'd1};
    n_checks++; if (obs1 !== e1) $display("FAIL pre_reset_state act=%b exp=%b", obs1, e1); else n_pass++;
    // Mid-cycle assertion must act without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    e1 = {4'b1010, 4'b0101, 4'b0000, 2'd0};
    n_checks++; if (obs1 !== e1) $display("FAIL async_reset_dut1 act=%b exp=%b", obs1, e1); else n_pass++;
    n_checks++; if (obs2 !== e2) $display("FAIL async_reset_dut2 act=%b exp=%b", obs2, e2); else n_pass++;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_sr_basics();
    logic [13:0] e1;
    logic [19:0] e2;
    step(1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0);
    step(1'b1, 2'd0, 4'b0011, 4'b1100, 1'b0);
    e1 = {4'b0011, 4'b1100, 4'b0000, 2'd0};
    n_checks++; if (obs1 !== e1) $display("FAIL sr_set_reset act=%b exp=%b", obs1, e1); else n_pass++;
    step(1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0);
    n_checks++; if (obs1 !== e1) $display("FAIL sr_hold act=%b exp=%b", obs1, e1); else n_pass++;
    step(1'b1, 2'd0, 4'b1111, 4'b1111, 1'b0);
    e1 = {4'b0011, 4'b1100, 4'b1111, 2'd1};
    e2 = {4'b1111, 4'b0000, 4'b1111, 8'd1};
    n_checks++; if (obs1 !== e1) $display("FAIL sr_conflict_hold act=%b exp=%b", obs1, e1); else n_pass++;
    n_checks++; if (obs2 !== e2) $display("FAIL sr_conflict_set act=%b exp=%b", obs2, e2); else n_pass++;
  endtask

  task automatic test_jk_toggle();
    logic [13:0] e1;
    logic [19:0] e2;
    step(1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0);
    for (int n = 0; n < 3; n++) begin
      step(1'b1, 2'd1, 4'b1111, 4'b1111, 1'b0);
      e1 = {((n % 2) == 0) ? 4'b1111 : 4'b0000, ((n % 2) == 0) ? 4'b0000 : 4'b1111, 4'b1111, 2'd1};
      n_checks++; if (obs1 !== e1) $display("FAIL jk_toggle_%0d act=%b exp=%b", n, obs1, e1); else n_pass++;
    end
    e2 = {4'b1111, 4'b0000, 4'b1111, 8'd1};
    n_checks++; if (obs2 !== e2) $display("FAIL jk_toggle_dut2 act=%b exp=%b", obs2, e2); else n_pass++;
  endtask

  task automatic test_dt_enable();
    logic [13:0] e1;
    step(1'b1, 2'd2, 4'b0110, 4'b0000, 1'b0);
    e1 = {4'b0110, 4'b1001, 4'b1111, 2'd1};
    n_checks++; if (obs1 !== e1) $display("FAIL d_load act=%b exp=%b", obs1, e1); else n_pass++;
    step(1'b0, 2'd3, 4'b0101, 4'b0000, 1'b0);
    step(1'b0, 2'd3, 4'b0101, 4'b0000, 1'b0);
    n_checks++; if (obs1 !== e1) $display("FAIL en_low_hold act=%b exp=%b", obs1, e1); else n_pass++;
    // Disabled cycle must ignore both a clear request and a conflict.
    step(1'b0, 2'd0, 4'b1111, 4'b1111, 1'b1);
    n_checks++; if (obs1 !== e1) $display("FAIL en_low_ignore_clr act=%b exp=%b", obs1, e1); else n_pass++;
    step(1'b1, 2'd3, 4'b0101, 4'b0000, 1'b0);
    e1 = {4'b0011, 4'b1100, 4'b1111, 2'd1};
    n_checks++; if (obs1 !== e1) $display("FAIL t_toggle act=%b exp=%b", obs1, e1); else n_pass++;
  endtask

  task automatic test_saturation();
    logic [13:0] e1;
    logic [19:0] e2;
    int          exp_cnt;
    step(1'b1, 2'd2, 4'b0000, 4'b0000, 1'b1);
    e1 = {4'b0000, 4'b1111, 4'b0000, 2'd0};
    n_checks++; if (obs1 !== e1) $display("FAIL clear_no_event act=%b exp=%b", obs1, e1); else n_pass++;
    for (int n = 1; n <= 5; n++) begin
      step(1'b1, 2'd0, 4'b0001, 4'b0001, 1'b0);
      exp_cnt = (n > 3) ? 3 : n;
      e1 = {4'b0000, 4'b1111, 4'b0001, 2'(exp_cnt)};
      n_checks++; if (obs1 !== e1) $display("FAIL cnt_sat_%0d act=%b exp=%b", n, obs1, e1); else n_pass++;
    end
    e2 = {4'b0001, 4'b1110, 4'b0001, 8'd5};
    n_checks++; if (obs2 !== e2) $display("FAIL cnt_wide_dut2 act=%b exp=%b", obs2, e2); else n_pass++;
  endtask

  task automatic test_clear_collision();
    logic [13:0] e1;
    logic [19:0] e2;
    step(1'b1, 2'd0, 4'b0100, 4'b0100, 1'b1);
    e1 = {4'b0000, 4'b1111, 4'b0100, 2'd1};
    e2 = {4'b0101, 4'b1010, 4'b0100, 8'd1};
    n_checks++; if (obs1 !== e1) $display("FAIL clr_collision act=%b exp=%b", obs1, e1); else n_pass++;
    n_checks++; if (obs2 !== e2) $display("FAIL clr_collision_dut2 act=%b exp=%b", obs2, e2); else n_pass++;
    step(1'b1, 2'd0, 4'b0000, 4'b0000, 1'b1);
    e1 = {4'b0000, 4'b1111, 4'b0000, 2'd0};
    n_checks++; if (obs1 !== e1) $display("FAIL clr_plain act=%b exp=%b", obs1, e1); else n_pass++;
  endtask

  task automatic test_random();
    logic [13:0] e1;
    logic [19:0] e2;
    for (int n = 0; n < 300; n++) begin
      step(($urandom % 4) != 0, 2'($urandom % 4), 4'($urandom), 4'($urandom), ($urandom % 8) == 0);
      e1 = {mq[0], ~mq[0], mill[0], 2'(mcnt[0])};
      e2 = {mq[1], ~mq[1], mill[1], 8'(mcnt[1])};
      n_checks++; if (obs1 !== e1) $display("FAIL random_dut1_%0d act=%b exp=%b", n, obs1, e1); else n_pass++;
      n_checks++; if (obs2 !== e2) $display("FAIL random_dut2_%0d act=%b exp=%b", n, obs2, e2); else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; S = '0; R = '0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_sr_basics();
    test_jk_toggle();
    test_dt_enable();
    test_saturation();
    test_clear_collision();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
